mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port 1024x16 program/data memory between two requesters.
  - Port A: the processor core.
  - Port B: a host/loader path, e.g. the I2C program loader or a sample-table DMA.
- Sits between the requesters and the memory macro.
- Performs per-cycle round-robin arbitration, with an optional bounded burst lock for port B.
- Routes read data back to the winning port with fixed 1-cycle latency.

Parameters:
- AW, 10, memory address width.
- DW, 16, memory data width.
- MAX_LOCK, 8, maximum consecutive locked grants to port B before port A must be served (range 1..255).
- PROT_LIMIT, 10'd256, first port-B-writable address (used only when the optional feature is enabled).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_a  in  1  port A request; held until gnt_a.
- we_a  in  1  port A write enable.
- addr_a  in  AW  port A address.
- wdata_a  in  DW  port A write data.
- gnt_a  out  1  port A granted this cycle (combinational).
- rvalid_a  out  1  port A read data valid (registered).
- rdata_a  out  DW  port A read data (registered).
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as port A, for port B.
- lock_b  in  1  port B requests burst ownership.
- mem_addr  out  AW  memory address (combinational).
- mem_we  out  1  memory write enable (combinational).
- mem_wdata  out  DW  memory write data (combinational).
- mem_rdata  in  DW  memory read data, valid the cycle after the address.
- prot_err  out  1  sticky protected-write flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset values:
  - gnt_a/b=0, rvalid_a/b=0, rdata_a/b=0, prot_err=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - last_gnt=B, so A wins the first contention.
  - lock_cnt=0, state=ARB.
  - A read outstanding at reset is dropped; no rvalid is issued afterwards.
- Transaction model:
  - Cycle N: at most one gnt is high; the memory bus carries the granted port's addr/we/wdata.
  - Cycle N+1: if cycle N was a read, rvalid_x=1 and rdata_x=mem_rdata on the same port.
  - rdata_x holds its value until the next read on that port.
  - Writes produce no rvalid.
- No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Requester rule: addr/we/wdata must be stable while req is high. After gnt, the requester may present a new request in the next cycle (back-to-back at one per cycle).
- State ARB:
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port not equal to last_gnt.
  - last_gnt updates on every grant.
  - If gnt_b and lock_b: go to LOCK_B with lock_cnt=1.
- State LOCK_B:
  - req_b&&lock_b&&lock_cnt<MAX_LOCK: grant B (even if req_a), lock_cnt++.
  - Otherwise: arbitrate as in ARB for this same cycle, lock_cnt=0, go to ARB.
  - When exiting because lock_cnt reached MAX_LOCK, last_gnt=B, so a pending A wins.
- Starvation bound: A waits at most MAX_LOCK+1 cycles.
- lock_b without req_b is ignored.

Optional Feature:
- Macro MEM_ARB_WRITE_PROT_EN.
- Defined:
  - A port-B write with addr_b<PROT_LIMIT is still granted (handshake completes) but mem_we is forced 0.
  - prot_err is set and stays set until rst.
  - Port-A writes and all reads are unaffected.
- Undefined: no check; prot_err is tied 0.

Test Plan:
- Reset, then req_a read addr 0x005 (memory holds 0x1234) → gnt_a in that cycle; next cycle rvalid_a=1, rdata_a=0x1234, rvalid_b=0.
- req_a and req_b both held for 4 cycles, reads → grants alternate A,B,A,B; each rvalid lands on the correct port one cycle later.
- req_b+lock_b held, MAX_LOCK=8, req_a held → B granted 8 consecutive cycles, A granted on cycle 9, then alternation resumes.
- Port B writes 0xBEEF to addr 0x3FF, then port A reads 0x3FF → mem_we=1 only in the write cycle; rdata_a=0xBEEF.
- rst asserted in the cycle after a read grant → rvalid stays 0, all outputs return to reset values, next contention grants A first.
- With MEM_ARB_WRITE_PROT_EN, port B writes addr 0x010 → gnt_b=1, mem_we=0, prot_err=1 sticky; a write to 0x100 has mem_we=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between port A (core) and
// port B (host/loader). Per-cycle round-robin grant, optional bounded burst
// lock for port B, read data routed back to the winner one cycle later.
// Optional feature: define MEM_ARB_WRITE_PROT_EN to block port-B writes
// below PROT_LIMIT and raise a sticky prot_err flag.
module mem_arbiter #(
    parameter int              AW         = 10,
    parameter int              DW         = 16,
    parameter int              MAX_LOCK   = 8,
    parameter logic [AW-1:0]   PROT_LIMIT = 10'd256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    output logic          rvalid_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_b,
    input  logic          lock_b,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          prot_err
);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCK_B = 1'b1
    } state_t;

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    state_t        state_r;
    logic          last_gnt_b_r;     // 1: port B held the most recent grant
    logic [7:0]    lock_cnt_r;
    logic          lock_hold_s;
    logic          gnt_a_s;
    logic          gnt_b_s;
    logic          bus_we_s;
    logic          prot_block_s;
    logic          rd_pend_a_r;
    logic          rd_pend_b_r;
    logic [DW-1:0] rdata_hold_a_r;
    logic [DW-1:0] rdata_hold_b_r;

    // Grant decision: a live burst lock wins outright, otherwise round-robin.
    always_comb begin
        gnt_a_s     = 1'b0;
        gnt_b_s     = 1'b0;
        lock_hold_s = (state_r == ST_LOCK_B) && req_b && lock_b &&
                      (lock_cnt_r < MAX_LOCK_C);
        if (rst) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else if (lock_hold_s) begin
            gnt_b_s = 1'b1;
        end else if (req_a && req_b) begin
            gnt_a_s = last_gnt_b_r;
            gnt_b_s = ~last_gnt_b_r;
        end else begin
            gnt_a_s = req_a;
            gnt_b_s = req_b;
        end
    end

    // Memory bus mux: the granted port drives the bus, idle bus is all zero.
    always_comb begin
        mem_addr  = {AW{1'b0}};
        bus_we_s  = 1'b0;
        mem_wdata = {DW{1'b0}};
        if (gnt_a_s) begin
            mem_addr  = addr_a;
            bus_we_s  = we_a;
            mem_wdata = wdata_a;
        end else if (gnt_b_s) begin
            mem_addr  = addr_b;
            bus_we_s  = we_b;
            mem_wdata = wdata_b;
        end else begin
            mem_addr  = {AW{1'b0}};
            bus_we_s  = 1'b0;
            mem_wdata = {DW{1'b0}};
        end
    end

`ifdef MEM_ARB_WRITE_PROT_EN
    logic prot_err_r;

    assign prot_block_s = gnt_b_s && we_b && (addr_b < PROT_LIMIT);
    assign prot_err     = prot_err_r;

    // Sticky flag for a blocked port-B write; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prot_err_r <= 1'b0;
        end else if (prot_block_s) begin
            prot_err_r <= 1'b1;
        end else begin
            prot_err_r <= prot_err_r;
        end
    end
`else
    assign prot_block_s = 1'b0;
    assign prot_err     = 1'b0;
`endif

    assign gnt_a  = gnt_a_s;
    assign gnt_b  = gnt_b_s;
    assign mem_we = bus_we_s && !prot_block_s;

    // Arbitration FSM: round-robin history and the port-B burst lock counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_ARB;
            last_gnt_b_r <= 1'b1;
            lock_cnt_r   <= 8'd0;
        end else begin
            if (gnt_a_s) begin
                last_gnt_b_r <= 1'b0;
            end else if (gnt_b_s) begin
                last_gnt_b_r <= 1'b1;
            end else begin
                last_gnt_b_r <= last_gnt_b_r;
            end
            case (state_r)
                ST_ARB: begin
                    if (gnt_b_s && lock_b) begin
                        state_r    <= ST_LOCK_B;
                        lock_cnt_r <= 8'd1;
                    end else begin
                        state_r    <= ST_ARB;
                        lock_cnt_r <= 8'd0;
                    end
                end
                ST_LOCK_B: begin
                    if (lock_hold_s) begin
                        state_r    <= ST_LOCK_B;
                        lock_cnt_r <= lock_cnt_r + 8'd1;
                    end else begin
                        state_r    <= ST_ARB;
                        lock_cnt_r <= 8'd0;
                    end
                end
                default: begin
                    state_r    <= ST_ARB;
                    lock_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // Read tracking: remember which port owns the read in flight and keep the
    // last returned word so rdata holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_a_r    <= 1'b0;
            rd_pend_b_r    <= 1'b0;
            rdata_hold_a_r <= {DW{1'b0}};
            rdata_hold_b_r <= {DW{1'b0}};
        end else begin
            rd_pend_a_r <= gnt_a_s && !we_a;
            rd_pend_b_r <= gnt_b_s && !we_b;
            if (rd_pend_a_r) begin
                rdata_hold_a_r <= mem_rdata;
            end else begin
                rdata_hold_a_r <= rdata_hold_a_r;
            end
            if (rd_pend_b_r) begin
                rdata_hold_b_r <= mem_rdata;
            end else begin
                rdata_hold_b_r <= rdata_hold_b_r;
            end
        end
    end

    // The memory output register supplies the data in the return cycle; a
    // read in flight when reset arrives is dropped.
    assign rvalid_a = rd_pend_a_r && !rst;
    assign rvalid_b = rd_pend_b_r && !rst;
    assign rdata_a  = rst ? {DW{1'b0}} : (rd_pend_a_r ? mem_rdata : rdata_hold_a_r);
    assign rdata_b  = rst ? {DW{1'b0}} : (rd_pend_b_r ? mem_rdata : rdata_hold_b_r);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed cycle-by-cycle stimulus with expected
// grants checked directly and expected read data queued for a monitor.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req_a, we_a, req_b, we_b, lock_b;
    logic [9:0]  addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [15:0] rdata_a, rdata_b;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        prot_err;

    logic [15:0] mem [0:1023];
    logic [15:0] qa [$];
    logic [15:0] qb [$];
    int          tests;
    int          fails;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .lock_b(lock_b),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .prot_err(prot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory model, read-first, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid must match the oldest expected read for that port.
    always @(negedge clk) begin
        if (rvalid_a) begin
            if (qa.size() == 0) begin
                tests++; fails++;
                $display("FAIL rvalid_a_unexpected: got rvalid_a=1 rdata_a=0x%0h, expected no read", rdata_a);
            end else begin
                check("rdata_a", {16'h0, rdata_a}, {16'h0, qa.pop_front()});
            end
        end
        if (rvalid_b) begin
            if (qb.size() == 0) begin
                tests++; fails++;
                $display("FAIL rvalid_b_unexpected: got rvalid_b=1 rdata_b=0x%0h, expected no read", rdata_b);
            end else begin
                check("rdata_b", {16'h0, rdata_b}, {16'h0, qb.pop_front()});
            end
        end
    end

    // One bus cycle: drive requests, check grant and bus at negedge, queue
    // the expected read word for the granted port.
    task automatic step(input logic ra, input logic wa, input logic [9:0] aa, input logic [15:0] da,
                        input logic rb, input logic wb, input logic [9:0] ab, input logic [15:0] db,
                        input logic lk, input logic ega, input logic egb, input logic ewe,
                        input logic push, input logic [15:0] erd, input string tag);
        logic [9:0]  exp_addr;
        logic [15:0] exp_wd;
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db; lock_b = lk;
        exp_addr = ega ? aa : (egb ? ab : 10'h0);
        exp_wd   = ega ? da : (egb ? db : 16'h0);
        @(negedge clk);
        check({tag, ".gnt_a"}, {31'h0, gnt_a}, {31'h0, ega});
        check({tag, ".gnt_b"}, {31'h0, gnt_b}, {31'h0, egb});
        check({tag, ".mem_we"}, {31'h0, mem_we}, {31'h0, ewe});
        check({tag, ".mem_addr"}, {22'h0, mem_addr}, {22'h0, exp_addr});
        check({tag, ".mem_wdata"}, {16'h0, mem_wdata}, {16'h0, exp_wd});
        if (push && ega) qa.push_back(erd);
        if (push && egb) qb.push_back(erd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 10'h0, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 16'h0, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".gnt_a"}, {31'h0, gnt_a}, 32'h0);
        check({tag, ".gnt_b"}, {31'h0, gnt_b}, 32'h0);
        check({tag, ".rvalid_a"}, {31'h0, rvalid_a}, 32'h0);
        check({tag, ".rvalid_b"}, {31'h0, rvalid_b}, 32'h0);
        check({tag, ".rdata_a"}, {16'h0, rdata_a}, 32'h0);
        check({tag, ".rdata_b"}, {16'h0, rdata_b}, 32'h0);
        check({tag, ".mem_we"}, {31'h0, mem_we}, 32'h0);
        check({tag, ".mem_addr"}, {22'h0, mem_addr}, 32'h0);
        check({tag, ".mem_wdata"}, {16'h0, mem_wdata}, 32'h0);
        check({tag, ".prot_err"}, {31'h0, prot_err}, 32'h0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        mem[10'h005] = 16'h1234;
        mem[10'h010] = 16'h1111;
        mem[10'h020] = 16'hA000;
        mem[10'h021] = 16'hA001;
        mem[10'h022] = 16'hA002;
        mem[10'h030] = 16'hB000;
        mem[10'h031] = 16'hB001;
        rst = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = 10'h0; wdata_a = 16'h0;
        req_b = 1'b0; we_b = 1'b0; addr_b = 10'h0; wdata_b = 16'h0; lock_b = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read on port A
        step(1'b1, 1'b0, 10'h005, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, "rd_a");
        idle("rd_a_ret");

        // Port B alone, then both contending: A,B,A,B
        step(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b0, 10'h010, 16'h0, 1'b0,
             1'b0, 1'b1, 1'b0, 1'b1, 16'h1111, "rd_b");
        step(1'b1, 1'b0, 10'h020, 16'h0, 1'b1, 1'b0, 10'h030, 16'h0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b1, 16'hA000, "alt1");
        step(1'b1, 1'b0, 10'h021, 16'h0, 1'b1, 1'b0, 10'h030, 16'h0, 1'b0,
             1'b0, 1'b1, 1'b0, 1'b1, 16'hB000, "alt2");
        step(1'b1, 1'b0, 10'h021, 16'h0, 1'b1, 1'b0, 10'h031, 16'h0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b1, 16'hA001, "alt3");
        step(1'b1, 1'b0, 10'h022, 16'h0, 1'b1, 1'b0, 10'h031, 16'h0, 1'b0,
             1'b0, 1'b1, 1'b0, 1'b1, 16'hB001, "alt4");
        step(1'b1, 1'b0, 10'h022, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b1, 16'hA002, "alt5");

        // Burst lock: 8 B grants, A on the ninth, then alternation
        step(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b0, 10'h030, 16'h0, 1'b1,
             1'b0, 1'b1, 1'b0, 1'b1, 16'hB000, "lock1");
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 10'h020, 16'h0, 1'b1, 1'b0, 10'h030, 16'h0, 1'b1,
                 1'b0, 1'b1, 1'b0, 1'b1, 16'hB000, "lockn");
        end
        step(1'b1, 1'b0, 10'h020, 16'h0, 1'b1, 1'b0, 10'h030, 16'h0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b1, 16'hA000, "lock_rel_a");
        step(1'b1, 1'b0, 10'h021, 16'h0, 1'b1, 1'b0, 10'h030, 16'h0, 1'b0,
             1'b0, 1'b1, 1'b0, 1'b1, 16'hB000, "post_b");
        step(1'b1, 1'b0, 10'h021, 16'h0, 1'b1, 1'b0, 10'h031, 16'h0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b1, 16'hA001, "post_a");
        step(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b0, 10'h031, 16'h0, 1'b0,
             1'b0, 1'b1, 1'b0, 1'b1, 16'hB001, "post_b2");
        idle("lock_ret");

        // Port B write then port A read back
        step(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b1, 10'h3FF, 16'hBEEF, 1'b0,
             1'b0, 1'b1, 1'b1, 1'b0, 16'h0, "wr_b");
        step(1'b1, 1'b0, 10'h3FF, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF, "rd_back");
        idle("rd_back_ret");

        // Reset right after a read grant drops the read
        step(1'b1, 1'b0, 10'h005, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "rd_pre_rst");
        rst = 1'b1;
        req_a = 1'b0;
        @(negedge clk);
        check_reset_outputs("in_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 10'h020, 16'h0, 1'b1, 1'b0, 10'h030, 16'h0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b1, 16'hA000, "rst_cont_a");
        step(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b0, 10'h030, 16'h0, 1'b0,
             1'b0, 1'b1, 1'b0, 1'b1, 16'hB000, "rst_cont_b");
        idle("rst_cont_ret");

        // Port-B writes below and at the protection limit
`ifdef MEM_ARB_WRITE_PROT_EN
        step(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b1, 10'h010, 16'h5555, 1'b0,
             1'b0, 1'b1, 1'b0, 1'b0, 16'h0, "wr_prot");
        check("prot_err_set", {31'h0, prot_err}, 32'h1);
        step(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b1, 10'h100, 16'h6666, 1'b0,
             1'b0, 1'b1, 1'b1, 1'b0, 16'h0, "wr_open");
        check("prot_err_sticky", {31'h0, prot_err}, 32'h1);
`else
        step(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b1, 10'h010, 16'h5555, 1'b0,
             1'b0, 1'b1, 1'b1, 1'b0, 16'h0, "wr_low");
        check("prot_err_tied", {31'h0, prot_err}, 32'h0);
        step(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b1, 10'h100, 16'h6666, 1'b0,
             1'b0, 1'b1, 1'b1, 1'b0, 16'h0, "wr_high");
        check("prot_err_tied2", {31'h0, prot_err}, 32'h0);
`endif
        idle("end1");
        idle("end2");

        check("qa_drained", qa.size(), 32'h0);
        check("qb_drained", qb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
